booth_serial_mac: RTL and testbench

Digit-serial radix-4 Booth multiply-accumulate engine for the output-stationary systolic PE. It accepts one signed 8x8 operand pair per handshake and processes one Booth digit of `a` per cycle through a partial-product generator sub-module. Each sign-extended, shifted partial product is added into an internal accumulator. On the last pair of a dot product it presents the accumulated sum downstream with a valid/ready handshake.

---
 rtl/booth_serial_mac_pkg.sv | 38 +++
 rtl/booth_serial_mac_if.sv | 29 ++
 rtl/booth_pp_gen_r4.sv | 32 +++
 rtl/booth_serial_mac.sv | 138 +++++++++++++
 tb/tb_booth_serial_mac.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/booth_serial_mac_pkg.sv
`default_nettype none
// ============================================================================
// booth_mac_pkg : shared types and constants for the radix-4 Booth serial MAC
// Revision      : 1.0
// ============================================================================
package booth_mac_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int PP_W       = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      OUT  = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      SEL_ZERO = 3'd0,
      SEL_P1   = 3'd1,
      SEL_P2   = 3'd2,
      SEL_N1   = 3'd3,
      SEL_N2   = 3'd4
   } booth_sel_t;

   function automatic booth_sel_t booth_decode(input logic [2:0] digit);
      booth_sel_t sel;
      case (digit)
         3'b001, 3'b010: sel = SEL_P1;
         3'b011:         sel = SEL_P2;
         3'b100:         sel = SEL_N2;
         3'b101, 3'b110: sel = SEL_N1;
         default:        sel = SEL_ZERO;
      endcase
      return sel;
   endfunction

endpackage
`default_nettype wire

// File: rtl/booth_serial_mac_if.sv
`default_nettype none
// ============================================================================
// booth_serial_mac_if : operand/result handshake bundle for booth_serial_mac
// Revision            : 1.0
// ============================================================================
interface booth_serial_mac_if #(
   parameter int ACC_W = 24
);
   logic                    in_valid;
   logic                    in_ready;
   logic signed [7:0]       in_a;
   logic signed [7:0]       in_b;
   logic                    in_last;
   logic                    acc_clr;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [ACC_W-1:0] out_data;

   modport master (
      output in_valid, in_a, in_b, in_last, acc_clr, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_a, in_b, in_last, acc_clr, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface
`default_nettype wire

// File: rtl/booth_pp_gen_r4.sv
`default_nettype none
// ============================================================================
// booth_pp_gen_r4 : combinational radix-4 Booth partial-product selector
// Revision        : 1.0
// ============================================================================
module booth_pp_gen_r4
   import booth_mac_pkg::*;
(
   input  logic [2:0]      i_digit,
   input  logic [7:0]      i_b,
   input  logic [8:0]      i_b_neg,
   output logic [PP_W-1:0] o_pp
);

   booth_sel_t w_sel;

   assign w_sel = booth_decode(i_digit);

   // 10 bits hold +/-2b for b=-128 without truncation
   always_comb begin
      o_pp = '0;
      case (w_sel)
         SEL_P1:  o_pp = {{2{i_b[7]}}, i_b};
         SEL_P2:  o_pp = {i_b[7], i_b, 1'b0};
         SEL_N1:  o_pp = {i_b_neg[8], i_b_neg};
         SEL_N2:  o_pp = {i_b_neg, 1'b0};
         default: o_pp = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/booth_serial_mac.sv
`default_nettype none
// ============================================================================
// booth_serial_mac : digit-serial radix-4 Booth multiply-accumulate engine
// Option           : BOOTH_SERIAL_MAC_SAT_EN enables saturating accumulation
// Revision         : 1.0
// ============================================================================
module booth_serial_mac
   import booth_mac_pkg::*;
#(
   parameter int ACC_W = 24
) (
   input  logic               clk,
   input  logic               rst_n,
   booth_serial_mac_if.slave  bus
);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic signed [7:0]       r_a;
   logic [7:0]              r_b;
   logic [8:0]              r_b_neg;
   logic                    r_last;
   logic [1:0]              r_cnt;
   logic signed [ACC_W-1:0] r_acc;
   logic signed [ACC_W-1:0] w_acc_nxt;
   logic signed [ACC_W-1:0] w_addend;
   logic [2:0]              w_digit;
   logic [PP_W-1:0]         w_pp;
   logic                    w_last_digit;
   logic                    w_acc_clear;

   assign w_last_digit = (r_cnt == 2'(NUM_DIGITS - 1));
   assign w_acc_clear  = ((r_state == IDLE) && bus.acc_clr) ||
                         ((r_state == OUT) && bus.out_ready);

   always_comb begin
      w_digit = '0;
      case (r_cnt)
         2'd0:    w_digit = {r_a[1:0], 1'b0};
         2'd1:    w_digit = r_a[3:1];
         2'd2:    w_digit = r_a[5:3];
         default: w_digit = r_a[7:5];
      endcase
   end

   booth_pp_gen_r4 u_pp_gen (
      .i_digit (w_digit),
      .i_b     (r_b),
      .i_b_neg (r_b_neg),
      .o_pp    (w_pp)
   );

   assign w_addend = {{(ACC_W - PP_W){w_pp[PP_W-1]}}, w_pp} << {r_cnt, 1'b0};

`ifdef BOOTH_SERIAL_MAC_SAT_EN
   localparam logic [ACC_W-1:0] c_sat_max = {1'b0, {(ACC_W - 1){1'b1}}};
   localparam logic [ACC_W-1:0] c_sat_min = {1'b1, {(ACC_W - 1){1'b0}}};

   logic             r_sat;
   logic [ACC_W:0]   w_sum_x;
   logic             w_ovf;

   assign w_sum_x = {r_acc[ACC_W-1], r_acc} + {w_addend[ACC_W-1], w_addend};
   assign w_ovf   = w_sum_x[ACC_W] ^ w_sum_x[ACC_W-1];

   // Sticky clamp: once saturated, later digits cannot pull the sum back
   always_comb begin
      w_acc_nxt = w_sum_x[ACC_W-1:0];
      if (r_sat) begin
         w_acc_nxt = r_acc;
      end else if (w_ovf) begin
         w_acc_nxt = w_sum_x[ACC_W] ? c_sat_min : c_sat_max;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sat <= 1'b0;
      end else if (w_acc_clear) begin
         r_sat <= 1'b0;
      end else if ((r_state == MUL) && w_ovf) begin
         r_sat <= 1'b1;
      end
   end
`else
   assign w_acc_nxt = r_acc + w_addend;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (bus.in_valid) w_state_nxt = MUL;
         MUL:     if (w_last_digit) w_state_nxt = r_last ? OUT : IDLE;
         OUT:     if (bus.out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_b_neg <= '0;
         r_last  <= 1'b0;
         r_cnt   <= '0;
         r_acc   <= '0;
      end else begin
         if (w_acc_clear) begin
            r_acc <= '0;
         end
         if ((r_state == IDLE) && bus.in_valid) begin
            r_a     <= bus.in_a;
            r_b     <= bus.in_b;
            r_b_neg <= ~{bus.in_b[7], bus.in_b} + 9'd1;
            r_last  <= bus.in_last;
            r_cnt   <= '0;
         end
         if (r_state == MUL) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 2'd1;
         end
      end
   end

   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = (r_state == OUT);
   assign bus.out_data  = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_booth_serial_mac.sv
`default_nettype none
// ============================================================================
// tb_booth_serial_mac : randomized self-checking bench with a behavioural MAC model
// Revision            : 1.0
// ============================================================================
module tb_booth_serial_mac;

   localparam int     ACC_W = 18;
   localparam longint c_max = (longint'(1) <<< (ACC_W - 1)) - 1;
   localparam longint c_min = -(longint'(1) <<< (ACC_W - 1));

   logic clk;
   logic rst_n;
   int   n_total;
   int   n_bad;

   longint m_acc;
   bit     m_sat;

   booth_serial_mac_if #(.ACC_W(ACC_W)) bus ();

   booth_serial_mac #(.ACC_W(ACC_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint rd_out();
      return longint'(bus.out_data);
   endfunction

   function automatic longint wrapw(input longint v);
      longint span;
      longint r;
      span = longint'(1) <<< ACC_W;
      r = v % span;
      if (r > c_max) r = r - span;
      if (r < c_min) r = r + span;
      return r;
   endfunction

   // Reference: value of each Booth digit times b, weighted by 4^k, added in order
   task automatic model_pair(input int a, input int b, input bit clr);
      int     hi, mid, lo;
      longint term, s;
      if (clr) begin
         m_acc = 0;
         m_sat = 0;
      end
      for (int k = 0; k < 4; k++) begin
         hi   = (a >>> (2 * k + 1)) & 1;
         mid  = (a >>> (2 * k)) & 1;
         lo   = (k == 0) ? 0 : ((a >>> (2 * k - 1)) & 1);
         term = longint'(lo + mid - 2 * hi) * longint'(b) * (longint'(1) <<< (2 * k));
         s    = m_acc + term;
`ifdef BOOTH_SERIAL_MAC_SAT_EN
         if (!m_sat) begin
            if (s > c_max) begin
               m_acc = c_max;
               m_sat = 1;
            end else if (s < c_min) begin
               m_acc = c_min;
               m_sat = 1;
            end else begin
               m_acc = s;
            end
         end
`else
         m_acc = wrapw(s);
`endif
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!bus.in_ready) chk("ready_timeout", 0, 1);
   endtask

   // Called at a negedge; returns at the negedge after the last digit edge
   task automatic send_pair(input logic signed [7:0] a, input logic signed [7:0] b,
                            input bit last, input bit clr);
      int n;
      wait_ready();
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_last  = last;
      bus.acc_clr  = clr;
      @(posedge clk);
      #1;
      model_pair(int'(a), int'(b), clr);
      bus.in_valid = 1'b1;
      bus.in_a     = 8'($urandom);
      bus.in_b     = 8'($urandom);
      bus.in_last  = 1'($urandom);
      bus.acc_clr  = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && !bus.out_valid && n < 20) begin
         n++;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.acc_clr  = 1'b0;
      chk("busy_cycles", n, 4);
   endtask

   task automatic get_result(input int hold);
      longint v;
      chk("out_valid", bus.out_valid, 1);
      chk("out_data", rd_out(), m_acc);
      v = rd_out();
      for (int i = 0; i < hold; i++) begin
         bus.acc_clr  = 1'b1;
         bus.in_valid = 1'b1;
         @(negedge clk);
         chk("hold_valid", bus.out_valid, 1);
         chk("hold_data", rd_out(), v);
         chk("hold_in_ready", bus.in_ready, 0);
      end
      bus.acc_clr   = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      m_acc = 0;
      m_sat = 0;
      @(negedge clk);
      chk("post_in_ready", bus.in_ready, 1);
      chk("post_valid", bus.out_valid, 0);
      chk("post_acc", rd_out(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic signed [7:0] ra, rb;
      bit                rl, rc;
      n_total       = 0;
      n_bad         = 0;
      m_acc         = 0;
      m_sat         = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_last   = 1'b0;
      bus.acc_clr   = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", rd_out(), 0);
      rst_n = 1'b1;
      @(negedge clk);

      send_pair(8'sd3, 8'sd5, 1, 0);
      chk("single_3x5", rd_out(), 15);
      get_result(0);

      send_pair(-8'sd128, -8'sd128, 1, 0);
      chk("neg128_sq", rd_out(), 16384);
      get_result(0);
      send_pair(8'sd127, -8'sd128, 1, 0);
      chk("127x_neg128", rd_out(), -16256);
      get_result(0);

      for (int i = 0; i < 3; i++) begin
         send_pair(8'sd127, 8'sd127, 0, 0);
         chk("partial_in_ready", bus.in_ready, 1);
      end
      send_pair(-8'sd1, 8'sd1, 1, 0);
      chk("four_pair_sum", rd_out(), 48386);
      get_result(0);

      send_pair(8'sd7, -8'sd9, 1, 0);
      get_result(10);

      for (int i = 0; i < 3; i++) send_pair(-8'sd128, -8'sd128, 0, 0);
      send_pair(8'sd1, 8'sd0, 1, 0);
      chk("sat_fits", rd_out(), 49152);
      get_result(0);
      for (int i = 0; i < 8; i++) send_pair(-8'sd128, -8'sd128, (i == 7), 0);
`ifdef BOOTH_SERIAL_MAC_SAT_EN
      chk("sat_overflow", rd_out(), 131071);
`else
      chk("wrap_overflow", rd_out(), -131072);
`endif
      get_result(0);

      // Reset during the third digit of an in-flight pair
      wait_ready();
      bus.in_valid = 1'b1;
      bus.in_a     = 8'sd100;
      bus.in_b     = 8'sd100;
      bus.in_last  = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_in_ready", bus.in_ready, 1);
      chk("async_rst_out_valid", bus.out_valid, 0);
      chk("async_rst_out_data", rd_out(), 0);
      m_acc = 0;
      m_sat = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_pair(8'sd2, 8'sd2, 1, 0);
      chk("after_rst", rd_out(), 4);
      get_result(0);

      send_pair(8'sd10, 8'sd10, 0, 0);
      send_pair(8'sd3, 8'sd4, 1, 1);
      chk("clr_with_accept", rd_out(), 12);
      get_result(0);

      for (int i = 0; i < 40; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rl = ($urandom_range(0, 3) == 0) || (i == 39);
         rc = ($urandom_range(0, 7) == 0);
         send_pair(ra, rb, rl, rc);
         if (rl) get_result(int'($urandom_range(0, 3)));
         else chk("rand_in_ready", bus.in_ready, 1);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
